vga_sync_timing: RTL and testbench

Raster timing generator for the VGA path. Consumes the one-`systemClk`-wide `pixelClk` strobe from the pixel clock generator and maintains horizontal and vertical position counters. From those counters it drives `hsync`, `vsync`, the active-video flag, pixel coordinates and line/frame start pulses. These outputs feed the Game-of-Life frame renderer and the VGA pins. Default parameters give 640x480 @ 60 Hz industry timing.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_sync_timing_if.sv | 41 ++++
 rtl/vga_axis_counter.sv | 67 ++++++
 rtl/vga_sync_timing.sv | 88 ++++++++
 tb/tb_vga_sync_timing.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing constants for the VGA raster path.
// Optional feature macro used by the VGA files: VGA_FRAME_COUNTER_EN.
package vga_pkg;

   localparam int COORD_W = 10;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FRONT  = 2'd1,
      SYNC   = 2'd2,
      BACK   = 2'd3
   } vga_phase_t;

endpackage

// File: rtl/vga_sync_timing_if.sv
// Raster timing bundle: pixelClk strobe in, sync/active/coordinates/pulses out.
// frameCount exists only when VGA_FRAME_COUNTER_EN is defined; hCnt/vCnt/hState/vState are debug taps.
interface vga_sync_timing_if;
   import vga_pkg::*;

   // pixelClk is a one-systemClk strobe with no backpressure: every strobe advances the raster.
   logic               pixelClk;
   logic               hsync;
   logic               vsync;
   logic               active;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic               lineStart;
   logic               frameStart;
`ifdef VGA_FRAME_COUNTER_EN
   logic [7:0]         frameCount;
`endif
   logic [COORD_W-1:0] hCnt;
   logic [COORD_W-1:0] vCnt;
   vga_phase_t         hState;
   vga_phase_t         vState;

   modport master (
      input  pixelClk,
`ifdef VGA_FRAME_COUNTER_EN
      output frameCount,
`endif
      output hsync, vsync, active, x, y, lineStart, frameStart,
      output hCnt, vCnt, hState, vState
   );

   modport slave (
      output pixelClk,
`ifdef VGA_FRAME_COUNTER_EN
      input  frameCount,
`endif
      input  hsync, vsync, active, x, y, lineStart, frameStart,
      input  hCnt, vCnt, hState, vState
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Exposes next-cycle values so the top can register its outputs with no skew.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE_LEN = DEF_H_ACTIVE,
   parameter int FP_LEN     = DEF_H_FP,
   parameter int SYNC_LEN   = DEF_H_SYNC,
   parameter int BP_LEN     = DEF_H_BP
) (
   input  logic               systemClk,
   input  logic               rst,
   input  logic               advance,
   output logic               wrap,
   output logic [COORD_W-1:0] cnt,
   output logic [COORD_W-1:0] cnt_nxt,
   output vga_phase_t         state,
   output logic               sync_nxt,
   output logic               active_nxt
);

   localparam int TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;
   localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);
   localparam logic [COORD_W-1:0] FRONT_AT = COORD_W'(ACTIVE_LEN);
   localparam logic [COORD_W-1:0] SYNC_AT  = COORD_W'(ACTIVE_LEN + FP_LEN);
   localparam logic [COORD_W-1:0] BACK_AT  = COORD_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN);

   if (TOTAL > 1024) begin : g_total_chk
      $error("vga_axis_counter: total length %0d exceeds 1024", TOTAL);
   end

   vga_phase_t state_nxt;

   assign wrap = advance && (cnt == LAST);

   always_ff @(posedge systemClk) begin
      if (rst) begin
         cnt   <= '0;
         state <= ACTIVE;
      end else if (advance) begin
         cnt   <= cnt_nxt;
         state <= state_nxt;
      end
   end

   // Phase changes are keyed on the count being entered, so they land exactly on region boundaries.
   always_comb begin
      cnt_nxt   = cnt;
      state_nxt = state;
      if (advance) begin
         cnt_nxt = wrap ? '0 : cnt + COORD_W'(1);
         case (state)
            ACTIVE:  if (cnt_nxt == FRONT_AT) state_nxt = FRONT;
            FRONT:   if (cnt_nxt == SYNC_AT)  state_nxt = SYNC;
            SYNC:    if (cnt_nxt == BACK_AT)  state_nxt = BACK;
            BACK:    if (wrap)                state_nxt = ACTIVE;
            default: state_nxt = ACTIVE;
         endcase
      end
   end

   always_comb begin
      sync_nxt   = (state_nxt == SYNC);
      active_nxt = (state_nxt == ACTIVE);
   end

endmodule

// File: rtl/vga_sync_timing.sv
// VGA raster timing generator: registered hsync/vsync/active/x/y and line/frame start pulses.
// Define VGA_FRAME_COUNTER_EN to add the 8-bit frameCount output.
module vga_sync_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0
) (
   input logic               systemClk,
   input logic               rst,
   vga_sync_timing_if.master vif
);

   localparam logic HS_ON = (HSYNC_POL != 0);
   localparam logic VS_ON = (VSYNC_POL != 0);

   logic               h_wrap, v_wrap;
   logic [COORD_W-1:0] h_cnt_nxt, v_cnt_nxt;
   logic               h_sync_nxt, v_sync_nxt;
   logic               h_act_nxt, v_act_nxt;

   vga_axis_counter #(
      .ACTIVE_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP)
   ) u_h (
      .systemClk (systemClk),
      .rst       (rst),
      .advance   (vif.pixelClk),
      .wrap      (h_wrap),
      .cnt       (vif.hCnt),
      .cnt_nxt   (h_cnt_nxt),
      .state     (vif.hState),
      .sync_nxt  (h_sync_nxt),
      .active_nxt(h_act_nxt)
   );

   // The vertical axis steps once per line, on the horizontal wrap.
   vga_axis_counter #(
      .ACTIVE_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP)
   ) u_v (
      .systemClk (systemClk),
      .rst       (rst),
      .advance   (h_wrap),
      .wrap      (v_wrap),
      .cnt       (vif.vCnt),
      .cnt_nxt   (v_cnt_nxt),
      .state     (vif.vState),
      .sync_nxt  (v_sync_nxt),
      .active_nxt(v_act_nxt)
   );

   always_ff @(posedge systemClk) begin
      if (rst) begin
         vif.hsync      <= !HS_ON;
         vif.vsync      <= !VS_ON;
         vif.active     <= 1'b1;
         vif.x          <= '0;
         vif.y          <= '0;
         vif.lineStart  <= 1'b0;
         vif.frameStart <= 1'b0;
      end else begin
         vif.lineStart  <= h_wrap;
         vif.frameStart <= v_wrap;
         if (vif.pixelClk) begin
            vif.hsync  <= h_sync_nxt ? HS_ON : !HS_ON;
            vif.vsync  <= v_sync_nxt ? VS_ON : !VS_ON;
            vif.active <= h_act_nxt && v_act_nxt;
            vif.x      <= (h_act_nxt && v_act_nxt) ? h_cnt_nxt : '0;
            vif.y      <= (h_act_nxt && v_act_nxt) ? v_cnt_nxt : '0;
         end
      end
   end

`ifdef VGA_FRAME_COUNTER_EN
   always_ff @(posedge systemClk) begin
      if (rst)         vif.frameCount <= 8'd0;
      else if (v_wrap) vif.frameCount <= vif.frameCount + 8'd1;
   end
`endif

endmodule

// File: tb/tb_vga_sync_timing.sv
// Bench for vga_sync_timing on a reduced raster (15x8); frameCount checks need VGA_FRAME_COUNTER_EN.
module tb_vga_sync_timing;
   import vga_pkg::*;

   localparam int HA = 8, HF = 2, HS = 3, HB = 2;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int W  = 45;

   logic systemClk = 1'b0;
   logic rst;
   always #5 systemClk = ~systemClk;

   vga_sync_timing_if vif ();

   vga_sync_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(0), .VSYNC_POL(0)
   ) dut (
      .systemClk(systemClk),
      .rst      (rst),
      .vif      (vif)
   );

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   int mh, mv;
   logic m_ls, m_fs;
   logic [7:0] m_fc;
   int ls_cnt, fs_cnt;

   typedef struct {
      int   steps;
      int   eh, ev;
      logic ehs, evs, eact;
      int   ex, ey;
      logic els, efs;
   } vec_t;
   vec_t tbl[10];

   // Expected outputs straight from region arithmetic on the model position.
   function automatic logic [W-1:0] model_vec();
      logic act, hs, vs;
      int ex, ey;
      act = (mh < HA) && (mv < VA);
      hs  = !((mh >= HA + HF) && (mh < HA + HF + HS));
      vs  = !((mv >= VA + VF) && (mv < VA + VF + VS));
      ex  = act ? mh : 0;
      ey  = act ? mv : 0;
      return {hs, vs, act, 10'(ex), 10'(ey), m_ls, m_fs, 10'(mh), 10'(mv)};
   endfunction

   function automatic logic [W-1:0] dut_vec();
      return {vif.hsync, vif.vsync, vif.active, vif.x, vif.y,
              vif.lineStart, vif.frameStart, vif.hCnt, vif.vCnt};
   endfunction

   task automatic cycle(input logic strobe, input logic do_rst);
      logic [W-1:0] got, expv;
      vif.pixelClk = strobe;
      rst          = do_rst;
      if (do_rst) begin
         mh = 0; mv = 0; m_ls = 1'b0; m_fs = 1'b0; m_fc = 8'd0;
      end else if (strobe) begin
         m_ls = (mh == HT - 1);
         m_fs = m_ls && (mv == VT - 1);
         if (m_ls) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh = mh + 1;
         end
         if (m_fs) m_fc = m_fc + 8'd1;
      end else begin
         m_ls = 1'b0; m_fs = 1'b0;
      end
      exp_q.push_back(model_vec());
      @(posedge systemClk);
      #1;
      got  = dut_vec();
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL scoreboard model(h=%0d,v=%0d) got=%h exp=%h", mh, mv, got, expv);
      end
      if (vif.lineStart === 1'b1)  ls_cnt++;
      if (vif.frameStart === 1'b1) fs_cnt++;
`ifdef VGA_FRAME_COUNTER_EN
      checks++;
      if (vif.frameCount !== m_fc) begin
         failures++;
         $display("FAIL frame_count got=%0d exp=%0d", vif.frameCount, m_fc);
      end
`endif
   endtask

   task automatic check_vec(input int i);
      logic [W-1:0] got, expv;
      got  = dut_vec();
      expv = {tbl[i].ehs, tbl[i].evs, tbl[i].eact, 10'(tbl[i].ex), 10'(tbl[i].ey),
              tbl[i].els, tbl[i].efs, 10'(tbl[i].eh), 10'(tbl[i].ev)};
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL table[%0d] got=%h exp=%h", i, got, expv);
      end
   endtask

   task automatic check_reset_state(input string name);
      logic [W-1:0] got, expv;
      got  = dut_vec();
      expv = {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 10'd0, 10'd0};
      checks++;
      if (got !== expv || vif.hState !== ACTIVE || vif.vState !== ACTIVE) begin
         failures++;
         $display("FAIL %s got=%h states=%0d/%0d exp=%h", name, got, vif.hState, vif.vState, expv);
      end
   endtask

   initial begin
      //          steps  h  v  hs vs act x  y  ls fs
      tbl[0] = '{1,      1, 0, 1, 1, 1,  1, 0, 0, 0};
      tbl[1] = '{7,      8, 0, 1, 1, 0,  0, 0, 0, 0};
      tbl[2] = '{2,     10, 0, 0, 1, 0,  0, 0, 0, 0};
      tbl[3] = '{2,     12, 0, 0, 1, 0,  0, 0, 0, 0};
      tbl[4] = '{1,     13, 0, 1, 1, 0,  0, 0, 0, 0};
      tbl[5] = '{2,      0, 1, 1, 1, 1,  0, 1, 1, 0};
      tbl[6] = '{3,      3, 1, 1, 1, 1,  3, 1, 0, 0};
      tbl[7] = '{57,     0, 5, 1, 0, 0,  0, 0, 1, 0};
      tbl[8] = '{30,     0, 7, 1, 1, 0,  0, 0, 1, 0};
      tbl[9] = '{15,     0, 0, 1, 1, 1,  0, 0, 1, 1};

      ls_cnt = 0; fs_cnt = 0;
      cycle(1'b0, 1'b1);
      cycle(1'b1, 1'b1);
      check_reset_state("reset_state");

      repeat (10) cycle(1'b0, 1'b0);
      check_reset_state("idle_hold");

      for (int i = 0; i < 10; i++) begin
         repeat (tbl[i].steps) cycle(1'b1, 1'b0);
         check_vec(i);
      end

      // One whole frame back-to-back: exactly one frameStart and VT lineStarts.
      ls_cnt = 0; fs_cnt = 0;
      repeat (HT * VT) cycle(1'b1, 1'b0);
      checks++;
      if (fs_cnt != 1 || ls_cnt != VT) begin
         failures++;
         $display("FAIL frame_pulses got fs=%0d ls=%0d exp fs=1 ls=%0d", fs_cnt, ls_cnt, VT);
      end

      // Strobe every 4th cycle, then random gaps, for a frame each.
      repeat (HT * VT) begin
         repeat (3) cycle(1'b0, 1'b0);
         cycle(1'b1, 1'b0);
      end
      repeat (HT * VT) begin
         repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0);
         cycle(1'b1, 1'b0);
      end
      repeat (300) cycle(1'($urandom_range(0, 1)), 1'b0);

      // Mid-frame reset with the strobe high must not produce a frameStart.
      for (int n = 0; n < HT * VT && !(mh == 5 && mv == 3); n++) cycle(1'b1, 1'b0);
      checks++;
      if (vif.hCnt !== 10'd5 || vif.vCnt !== 10'd3) begin
         failures++;
         $display("FAIL reach_mid got h=%0d v=%0d exp h=5 v=3", vif.hCnt, vif.vCnt);
      end
      cycle(1'b1, 1'b1);
      check_reset_state("mid_frame_reset");
      repeat (20) cycle(1'b1, 1'b0);

`ifdef VGA_FRAME_COUNTER_EN
      cycle(1'b0, 1'b1);
      repeat (HT * VT) cycle(1'b1, 1'b0);
      checks++;
      if (vif.frameCount !== 8'd1) begin
         failures++;
         $display("FAIL frame_count_one got=%0d exp=1", vif.frameCount);
      end
      repeat (255 * HT * VT) cycle(1'b1, 1'b0);
      checks++;
      if (vif.frameCount !== 8'd0) begin
         failures++;
         $display("FAIL frame_count_wrap got=%0d exp=0", vif.frameCount);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
